// File: rtl/div_issue_ctrl.sv
// Issue/sequencing control in front of the multi-cycle divider.
// Resolves RISC-V divide special cases locally and tags results for writeback.
module div_issue_ctrl #(
    parameter int XLEN     = 32,
    parameter int REG_ADDR = 5
) (
    input  logic                CLK,
    input  logic                rst,

    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [1:0]          req_op_i,
    input  logic [XLEN-1:0]     req_rs1_i,
    input  logic [XLEN-1:0]     req_rs2_i,
    input  logic [REG_ADDR-1:0] req_rd_i,
    input  logic                flush_i,

    output logic                div_valid_o,
    output logic [XLEN-1:0]     div_dividend_o,
    output logic [XLEN-1:0]     div_divisor_o,
    output logic [1:0]          div_op_o,
    input  logic [XLEN-1:0]     div_result_i,
    input  logic                div_ready_i,

    output logic                wb_valid_o,
    input  logic                wb_ready_i,
    output logic [XLEN-1:0]     wb_result_o,
    output logic [REG_ADDR-1:0] wb_rd_o,

    output logic                busy_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_BUSY   = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [XLEN-1:0]     r_div_dividend;
    logic [XLEN-1:0]     r_div_divisor;
    logic [1:0]          r_div_op;
    logic [XLEN-1:0]     r_wb_result;
    logic [REG_ADDR-1:0] r_wb_rd;

    logic                w_accept;
    logic                w_is_rem;
    logic                w_is_signed;
    logic                w_rd_zero;
    logic                w_div_zero;
    logic                w_overflow;
    logic                w_special;
    logic [XLEN-1:0]     w_special_res;
    logic                w_busy_done;

    // op[1] selects remainder, op[0] selects unsigned
    assign w_is_rem    = req_op_i[1];
    assign w_is_signed = ~req_op_i[0];
    assign w_rd_zero   = (req_rd_i == '0);
    assign w_div_zero  = (req_rs2_i == '0);
    assign w_overflow  = w_is_signed
                       & (req_rs1_i == MIN_INT)
                       & (req_rs2_i == '1);
    assign w_special   = w_rd_zero | w_div_zero | w_overflow;

    assign req_ready_o = (r_state == S_IDLE) & ~flush_i;
    assign w_accept    = req_valid_i & req_ready_o;
    assign w_busy_done = (r_state == S_BUSY) & div_ready_i & ~flush_i;

    always_comb begin
        w_special_res = '0;
        if (w_rd_zero) begin
            w_special_res = '0;
        end else if (w_div_zero) begin
            w_special_res = w_is_rem ? req_rs1_i : '1;
        end else if (w_overflow) begin
            w_special_res = w_is_rem ? '0 : req_rs1_i;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_special ? S_RESP : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_state_nxt = flush_i ? S_DRAIN : S_BUSY;
            end
            S_BUSY: begin
                if (div_ready_i) begin
                    w_state_nxt = flush_i ? S_IDLE : S_RESP;
                end else if (flush_i) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            // the divider must finish before another launch is allowed
            S_DRAIN: begin
                if (div_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RESP: begin
                if (wb_ready_i | flush_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_div_dividend <= '0;
            r_div_divisor  <= '0;
            r_div_op       <= '0;
            r_wb_result    <= '0;
            r_wb_rd        <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_wb_rd <= req_rd_i;
                if (w_special) begin
                    r_wb_result <= w_special_res;
                end else begin
                    r_div_dividend <= req_rs1_i;
                    r_div_divisor  <= req_rs2_i;
                    r_div_op       <= req_op_i;
                end
            end
            if (w_busy_done) begin
                r_wb_result <= div_result_i;
            end
        end
    end

    assign div_valid_o    = (r_state == S_LAUNCH);
    assign div_dividend_o = r_div_dividend;
    assign div_divisor_o  = r_div_divisor;
    assign div_op_o       = r_div_op;
    assign wb_valid_o     = (r_state == S_RESP);
    assign wb_result_o    = r_wb_result;
    assign wb_rd_o        = r_wb_rd;
    assign busy_o         = (r_state != S_IDLE);

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl; the divider is played by hand
// from the stimulus sequence.
module tb_div_issue_ctrl;

    localparam int XLEN     = 32;
    localparam int REG_ADDR = 5;

    logic                CLK = 1'b0;
    logic                rst;
    logic                req_valid_i;
    logic                req_ready_o;
    logic [1:0]          req_op_i;
    logic [XLEN-1:0]     req_rs1_i;
    logic [XLEN-1:0]     req_rs2_i;
    logic [REG_ADDR-1:0] req_rd_i;
    logic                flush_i;
    logic                div_valid_o;
    logic [XLEN-1:0]     div_dividend_o;
    logic [XLEN-1:0]     div_divisor_o;
    logic [1:0]          div_op_o;
    logic [XLEN-1:0]     div_result_i;
    logic                div_ready_i;
    logic                wb_valid_o;
    logic                wb_ready_i;
    logic [XLEN-1:0]     wb_result_o;
    logic [REG_ADDR-1:0] wb_rd_o;
    logic                busy_o;

    int n_vec = 0;
    int n_err = 0;
    int n_launch = 0;
    int base;

    div_issue_ctrl #(.XLEN(XLEN), .REG_ADDR(REG_ADDR)) dut (
        .CLK(CLK), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_rs1_i(req_rs1_i),
        .req_rs2_i(req_rs2_i), .req_rd_i(req_rd_i),
        .flush_i(flush_i),
        .div_valid_o(div_valid_o), .div_dividend_o(div_dividend_o),
        .div_divisor_o(div_divisor_o), .div_op_o(div_op_o),
        .div_result_i(div_result_i), .div_ready_i(div_ready_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_result_o(wb_result_o), .wb_rd_o(wb_rd_o),
        .busy_o(busy_o)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (div_valid_o) n_launch++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // present a request for one clock edge
    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_rs1_i   = a;
        req_rs2_i   = b;
        req_rd_i    = rd;
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic wb_take();
        wb_ready_i = 1'b1;
        tick();
        wb_ready_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid_i = 1'b0;
        req_op_i = 2'b00;
        req_rs1_i = '0;
        req_rs2_i = '0;
        req_rd_i = '0;
        flush_i = 1'b0;
        div_result_i = '0;
        div_ready_i = 1'b0;
        wb_ready_i = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_wbv", 32'(wb_valid_o), 0);
        chk("rst_divv", 32'(div_valid_o), 0);
        chk("rst_dvd", div_dividend_o, 0);
        chk("rst_dvs", div_divisor_o, 0);
        chk("rst_op", 32'(div_op_o), 0);
        chk("rst_wbres", wb_result_o, 0);
        chk("rst_wbrd", 32'(wb_rd_o), 0);
        rst = 1'b0;
        tick();
        chk("idle_ready", 32'(req_ready_o), 1);

        // DIV 100/7 rd=3, divider answers 14
        base = n_launch;
        issue(2'b00, 100, 7, 3);
        chk("t1_launch", 32'(div_valid_o), 1);
        chk("t1_busy_l", 32'(busy_o), 1);
        chk("t1_dvd", div_dividend_o, 100);
        chk("t1_dvs", div_divisor_o, 7);
        chk("t1_op", 32'(div_op_o), 0);
        tick();
        chk("t1_pulse1", 32'(div_valid_o), 0);
        chk("t1_busy_b", 32'(busy_o), 1);
        div_ready_i = 1'b1;
        div_result_i = 14;
        tick();
        div_ready_i = 1'b0;
        chk("t1_wbv", 32'(wb_valid_o), 1);
        chk("t1_res", wb_result_o, 14);
        chk("t1_rd", 32'(wb_rd_o), 3);
        chk("t1_busy_r", 32'(busy_o), 1);
        chk("t1_rdy_r", 32'(req_ready_o), 0);
        wb_take();
        chk("t1_wbv_off", 32'(wb_valid_o), 0);
        chk("t1_idle", 32'(busy_o), 0);
        chk("t1_nlaunch", n_launch - base, 1);

        // divide by zero
        base = n_launch;
        issue(2'b01, 5, 0, 4);
        chk("dz_divu_v", 32'(wb_valid_o), 1);
        chk("dz_divu_r", wb_result_o, 32'hFFFF_FFFF);
        chk("dz_divu_nl", 32'(div_valid_o), 0);
        wb_take();
        issue(2'b11, 5, 0, 4);
        chk("dz_remu_v", 32'(wb_valid_o), 1);
        chk("dz_remu_r", wb_result_o, 5);
        wb_take();

        // signed overflow
        issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5);
        chk("ov_div_v", 32'(wb_valid_o), 1);
        chk("ov_div_r", wb_result_o, 32'h8000_0000);
        wb_take();
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5);
        chk("ov_rem_v", 32'(wb_valid_o), 1);
        chk("ov_rem_r", wb_result_o, 0);
        wb_take();

        // rd = x0
        issue(2'b00, 9, 3, 0);
        chk("x0_v", 32'(wb_valid_o), 1);
        chk("x0_r", wb_result_o, 0);
        chk("x0_rd", 32'(wb_rd_o), 0);
        wb_take();
        chk("spec_nlaunch", n_launch - base, 0);

        // REM -7/2 flushed in second BUSY cycle
        base = n_launch;
        issue(2'b10, 32'hFFFF_FFF9, 2, 6);
        tick();
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("fl_wbv", 32'(wb_valid_o), 0);
        chk("fl_rdy0", 32'(req_ready_o), 0);
        tick();
        chk("fl_rdy1", 32'(req_ready_o), 0);
        chk("fl_busy", 32'(busy_o), 1);
        div_ready_i = 1'b1;
        div_result_i = 32'hFFFF_FFFF;
        tick();
        div_ready_i = 1'b0;
        chk("fl_rdy2", 32'(req_ready_o), 1);
        chk("fl_wbv2", 32'(wb_valid_o), 0);
        issue(2'b00, 20, 4, 7);
        tick();
        div_ready_i = 1'b1;
        div_result_i = 5;
        tick();
        div_ready_i = 1'b0;
        chk("af_res", wb_result_o, 5);
        chk("af_rd", 32'(wb_rd_o), 7);
        wb_take();
        chk("fl_nlaunch", n_launch - base, 2);

        // DIV 30/5 with writeback backpressure
        issue(2'b00, 30, 5, 9);
        tick();
        tick();
        div_ready_i = 1'b1;
        div_result_i = 6;
        tick();
        div_ready_i = 1'b0;
        req_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_v", 32'(wb_valid_o), 1);
            chk("bp_r", wb_result_o, 6);
            chk("bp_rd", 32'(wb_rd_o), 9);
            chk("bp_rdy", 32'(req_ready_o), 0);
            tick();
        end
        req_valid_i = 1'b0;
        wb_take();
        chk("bp_idle", 32'(busy_o), 0);
        chk("bp_wbv", 32'(wb_valid_o), 0);

        // flush and completion together in BUSY
        issue(2'b00, 20, 4, 1);
        tick();
        flush_i = 1'b1;
        div_ready_i = 1'b1;
        div_result_i = 5;
        tick();
        flush_i = 1'b0;
        div_ready_i = 1'b0;
        chk("fr_busy", 32'(busy_o), 0);
        chk("fr_wbv", 32'(wb_valid_o), 0);

        // flush in RESP drops the response
        issue(2'b01, 5, 0, 2);
        flush_i = 1'b1;
        chk("rf_v", 32'(wb_valid_o), 1);
        tick();
        flush_i = 1'b0;
        chk("rf_drop", 32'(wb_valid_o), 0);
        chk("rf_idle", 32'(busy_o), 0);

        // flush beats a simultaneous request
        flush_i = 1'b1;
        req_valid_i = 1'b1;
        chk("fq_rdy", 32'(req_ready_o), 0);
        tick();
        flush_i = 1'b0;
        req_valid_i = 1'b0;
        chk("fq_busy", 32'(busy_o), 0);
        chk("fq_wbv", 32'(wb_valid_o), 0);

        // spurious completion while idle
        div_ready_i = 1'b1;
        tick();
        div_ready_i = 1'b0;
        chk("sp_busy", 32'(busy_o), 0);

        // reset mid-operation
        issue(2'b00, 100, 7, 3);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_busy", 32'(busy_o), 0);
        chk("mr_dvd", div_dividend_o, 0);
        chk("mr_rd", 32'(wb_rd_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
